// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word aliases plus writeback select and halt-sequencing state.
package cpu_types_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

  // Encodings 4-7 are unused and fall back to the ALU result.
  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_LOAD = 3'd1,
    WB_NPC  = 3'd2,
    WB_UIMM = 3'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_unit.sv
// Final pipeline stage: register-file write, WB->EX forwarding, retire tracking
// and halt sequencing (dcache flush request, then core halt).
module writeback_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wb_en,
  input  logic             valid_i,
  input  logic             regWr_i,
  input  logic [4:0]       rd_i,
  input  logic [2:0]       rdSel_i,
  input  logic [31:0]      port_out_i,
  input  logic [31:0]      dmemload_i,
  input  logic [31:0]      zeroExt_i,
  input  logic [31:0]      npc_i,
  input  logic [31:0]      curr_pc_i,
  input  logic             halt_i,
  input  logic             flushed,
  output logic             rf_WEN,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic             fwd_en,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data,
  output logic             dcache_halt,
  output logic             cpu_halt,
  output logic [CNT_W-1:0] retired,
  output logic [31:0]      last_pc
);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  word_t            last_pc_q, last_pc_d;
  logic             dcache_halt_q, dcache_halt_d;
  logic             cpu_halt_q, cpu_halt_d;

  word_t    sel_data;
  wb_sel_t  sel;
  logic     retire;
  logic     wr_en;

  // Writeback data select.
  always_comb begin
    sel      = wb_sel_t'(rdSel_i);
    sel_data = port_out_i;
    case (sel)
      WB_ALU:  sel_data = port_out_i;
      WB_LOAD: sel_data = dmemload_i;
      WB_NPC:  sel_data = npc_i;
      WB_UIMM: sel_data = zeroExt_i;
      default: sel_data = port_out_i;
    endcase
  end

  // Retire/write qualification, counters and halt sequencing.
  always_comb begin
    state_d       = state_q;
    retired_d     = retired_q;
    last_pc_d     = last_pc_q;

    retire = wb_en & valid_i & (state_q == RUN);
    wr_en  = retire & regWr_i & (rd_i != 5'd0) & ~halt_i;

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      last_pc_d = curr_pc_i;
    end

    case (state_q)
      RUN:     if (retire && halt_i) state_d = DRAIN;
      DRAIN:   if (flushed)          state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    // Registered halt outputs track the state being entered.
    dcache_halt_d = (state_d != RUN);
    cpu_halt_d    = (state_d == HALTED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= RUN;
      retired_q     <= '0;
      last_pc_q     <= '0;
      dcache_halt_q <= 1'b0;
      cpu_halt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      retired_q     <= retired_d;
      last_pc_q     <= last_pc_d;
      dcache_halt_q <= dcache_halt_d;
      cpu_halt_q    <= cpu_halt_d;
    end
  end

  // Write port and forwarding path are zero whenever no write is taking place.
  always_comb begin
    rf_WEN   = wr_en;
    rf_wsel  = wr_en ? rd_i : 5'd0;
    rf_wdat  = wr_en ? sel_data : 32'd0;
    fwd_en   = rf_WEN;
    fwd_rd   = rf_wsel;
    fwd_data = rf_wdat;
  end

  assign dcache_halt = dcache_halt_q;
  assign cpu_halt    = cpu_halt_q;
  assign retired     = retired_q;
  assign last_pc     = last_pc_q;

endmodule
